training_sample_sequencer: RTL and testbench

//  Upstream feeder for the perceptron training datapath. Holds the training set in a local

---
 rtl/training_sample_sequencer_if.sv | 21 ++
 rtl/training_sample_sequencer.sv | 178 +++++++++++++++++
 tb/tb_training_sample_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/training_sample_sequencer_if.sv
// Sample stream between the training sequencer and the perceptron datapath.
// The master offers (x1, x2, t) with valid/ready; the slave returns per-sample results.
interface training_sample_sequencer_if;
  logic [6:0] x1;
  logic [6:0] x2;
  logic [1:0] t;
  logic       sample_valid;
  logic       sample_ready;
  logic       result_valid;
  logic       mismatch;

  modport master (
    output x1, x2, t, sample_valid,
    input  sample_ready, result_valid, mismatch
  );

  modport slave (
    input  x1, x2, t, sample_valid,
    output sample_ready, result_valid, mismatch
  );
endinterface

// File: rtl/training_sample_sequencer.sv
// Training-set store and epoch sequencer feeding the perceptron datapath one sample at a time.
// Stops on an error-free epoch or after MAX_EPOCH epochs and raises Finish_Flag.
module training_sample_sequencer #(
  parameter int unsigned DEPTH     = 200,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_EPOCH = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [6:0]            wr_x1,
  input  logic [6:0]            wr_x2,
  input  logic [1:0]            wr_t,
  input  logic [ADDR_W-1:0]     num_samples,
  input  logic                  start,
  training_sample_sequencer_if.master sif,
  output logic                  busy,
  output logic                  Finish_Flag,
  output logic                  converged,
  output logic [4:0]            epoch,
  output logic [ADDR_W-1:0]     sample_idx,
  output logic [7:0]            last_epoch_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef struct packed {
    logic [6:0] x1;
    logic [6:0] x2;
    logic [1:0] t;
  } sample_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  sample_t sample_mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [4:0]        epoch_q, epoch_d;
  logic [7:0]        err_q, err_d;
  logic [7:0]        last_err_q, last_err_d;
  logic              conv_q, conv_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  sample_t           smp_q, smp_d;

  logic [ADDR_W-1:0] num_clamped;
  logic              last_sample;
  logic [7:0]        err_inc;
  logic              mem_wr;

  // Writes land only while idle so an epoch always sees a stable training set.
  assign mem_wr = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE))
                  && ({1'b0, wr_addr} < CNT_W'(DEPTH));

  always_ff @(posedge Clk) begin
    if (mem_wr) begin
      sample_mem[wr_addr] <= {wr_x1, wr_x2, wr_t};
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    err_d      = err_q;
    last_err_d = last_err_q;
    conv_d     = conv_q;
    valid_d    = valid_q;
    smp_d      = smp_q;

    num_clamped = ({1'b0, num_samples} > CNT_W'(DEPTH)) ? ADDR_W'(DEPTH) : num_samples;
    last_sample = (CNT_W'(idx_q) + CNT_W'(1)) >= CNT_W'(num_q);
    err_inc     = err_q + 8'(sif.mismatch && (err_q != 8'hFF));

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d   = num_clamped;
          idx_d   = '0;
          epoch_d = '0;
          err_d   = '0;
          conv_d  = 1'b0;
          state_d = (num_clamped == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        smp_d   = sample_mem[idx_q];
        valid_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (sif.sample_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sif.result_valid) begin
          err_d = err_inc;
          if (!last_sample) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            // Epoch boundary: publish the error count, then decide stop or replay.
            last_err_d = err_inc;
            if (err_inc == 8'd0) begin
              conv_d  = 1'b1;
              state_d = S_DONE;
            end else if (epoch_q == 5'(MAX_EPOCH - 1)) begin
              conv_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              epoch_d = epoch_q + 5'd1;
              idx_d   = '0;
              err_d   = '0;
              state_d = S_FETCH;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    finish_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      idx_q      <= '0;
      epoch_q    <= '0;
      err_q      <= '0;
      last_err_q <= '0;
      conv_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      smp_q      <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      err_q      <= err_d;
      last_err_q <= last_err_d;
      conv_q     <= conv_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      smp_q      <= smp_d;
    end
  end

  assign sif.x1           = smp_q.x1;
  assign sif.x2           = smp_q.x2;
  assign sif.t            = smp_q.t;
  assign sif.sample_valid = valid_q;
  assign busy             = busy_q;
  assign Finish_Flag      = finish_q;
  assign converged        = conv_q;
  assign epoch            = epoch_q;
  assign sample_idx       = idx_q;
  assign last_epoch_err   = last_err_q;

endmodule

// File: tb/tb_training_sample_sequencer.sv
// Bench for training_sample_sequencer: scenario table, hand-written reset/abort/empty-run
// sequences and randomized runs checked against an epoch-level reference model.
module tb_training_sample_sequencer;
  localparam int unsigned DEPTH     = 200;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_EPOCH = 16;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_x1, wr_x2;
  logic [1:0]        wr_t;
  logic [ADDR_W-1:0] num_samples;
  logic              start;
  logic              busy, Finish_Flag, converged;
  logic [4:0]        epoch;
  logic [ADDR_W-1:0] sample_idx;
  logic [7:0]        last_epoch_err;

  training_sample_sequencer_if sif();

  training_sample_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_EPOCH(MAX_EPOCH)) dut (
    .Clk(Clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1), .wr_x2(wr_x2),
    .wr_t(wr_t), .num_samples(num_samples), .start(start), .sif(sif), .busy(busy),
    .Finish_Flag(Finish_Flag), .converged(converged), .epoch(epoch),
    .sample_idx(sample_idx), .last_epoch_err(last_epoch_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: memory image, mismatch plan per (epoch, idx), expected issue list.
  logic [6:0] m_x1 [DEPTH];
  logic [6:0] m_x2 [DEPTH];
  logic [1:0] m_t  [DEPTH];
  bit         mm   [MAX_EPOCH][DEPTH];

  typedef struct {
    int         idx;
    int         ep;
    logic [6:0] x1;
    logic [6:0] x2;
    logic [1:0] t;
  } issue_t;

  issue_t exp_q[$];
  int     exp_epoch, exp_last;
  bit     exp_conv;

  typedef struct {
    int n;
    int mode;
    bit rr;
    int stall;
    bit wr0;
    int e_issues;
    int e_epoch;
    bit e_conv;
    int e_last;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_x1"}, 32'(sif.x1), 0);
    chk({tag, "_x2"}, 32'(sif.x2), 0);
    chk({tag, "_t"}, 32'(sif.t), 0);
    chk({tag, "_valid"}, 32'(sif.sample_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finish"}, 32'(Finish_Flag), 0);
    chk({tag, "_conv"}, 32'(converged), 0);
    chk({tag, "_epoch"}, 32'(epoch), 0);
    chk({tag, "_idx"}, 32'(sample_idx), 0);
    chk({tag, "_lasterr"}, 32'(last_epoch_err), 0);
  endtask

  task automatic fill_mm(input int mode);
    for (int e = 0; e < int'(MAX_EPOCH); e++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        case (mode)
          0:       mm[e][i] = 1'b0;
          1:       mm[e][i] = (e == 0 && i == 2);
          2:       mm[e][i] = 1'b1;
          default: mm[e][i] = (e < 4) && ($urandom_range(0, 99) < 50 - 12 * e);
        endcase
      end
    end
  endtask

  // Epoch-level model: replay the whole set each epoch, stop on zero errors or the limit.
  task automatic build_model(input int n);
    int err;
    exp_q.delete();
    exp_epoch = 0;
    exp_conv  = 1'b0;
    exp_last  = 0;
    for (int e = 0; e < int'(MAX_EPOCH); e++) begin
      err = 0;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{i, e, m_x1[i], m_x2[i], m_t[i]});
        err += int'(mm[e][i]);
      end
      exp_epoch = e;
      exp_last  = (err > 255) ? 255 : err;
      if (err == 0) begin
        exp_conv = 1'b1;
        break;
      end
    end
  endtask

  // Starts a run and acts as the datapath until Finish_Flag (or reset abort at abort_ep).
  task automatic run(input int n, input bit rr, input int stall, input int abort_ep,
                     output int issues);
    int          budget, rv_delay;
    bit          rv_pend, pend_mm, stalled, do_abort;
    logic [15:0] prev;
    issue_t      it;
    issues   = 0;
    rv_pend  = 1'b0;
    rv_delay = 0;
    pend_mm  = 1'b0;
    stalled  = 1'b0;
    do_abort = 1'b0;
    prev     = '0;
    budget   = 40 * exp_q.size() + 100;
    sif.result_valid = 1'b0;
    sif.mismatch     = 1'b0;
    num_samples = ADDR_W'(n);
    start = 1'b1;
    tick;
    start = 1'b0;
    wr_en = 1'b0;
    while (!Finish_Flag && budget > 0 && !do_abort) begin
      budget--;
      if (stalled) begin
        chk("stall_valid", 32'(sif.sample_valid), 1);
        chk("stall_data", 32'({sif.x1, sif.x2, sif.t}), 32'(prev));
      end
      sif.result_valid = 1'b0;
      sif.mismatch     = 1'b0;
      if (rv_pend) begin
        if (rv_delay == 0) begin
          sif.result_valid = 1'b1;
          sif.mismatch     = pend_mm;
          rv_pend          = 1'b0;
        end else begin
          rv_delay--;
        end
      end else if (sif.sample_valid && $urandom_range(0, 3) == 0) begin
        sif.result_valid = 1'b1;
        sif.mismatch     = 1'b1;
      end
      sif.sample_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall > 0 && sif.sample_valid) begin
        sif.sample_ready = 1'b0;
        stall--;
      end
      // Start and writes while busy must both be ignored.
      start       = busy && ($urandom_range(0, 7) == 0);
      num_samples = ADDR_W'($urandom_range(0, 255));
      wr_en       = busy && ($urandom_range(0, 3) == 0);
      wr_addr     = ADDR_W'($urandom_range(0, 255));
      wr_x1       = 7'($urandom);
      wr_x2       = 7'($urandom);
      wr_t        = 2'($urandom);
      stalled     = sif.sample_valid && !sif.sample_ready;
      prev        = {sif.x1, sif.x2, sif.t};
      if (sif.sample_valid && sif.sample_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_issue: got idx %0d epoch %0d expected no further issue",
                   sample_idx, epoch);
        end else begin
          it = exp_q.pop_front();
          chk("issue_idx", 32'(sample_idx), 32'(it.idx));
          chk("issue_epoch", 32'(epoch), 32'(it.ep));
          chk("issue_x1", 32'(sif.x1), 32'(it.x1));
          chk("issue_x2", 32'(sif.x2), 32'(it.x2));
          chk("issue_t", 32'(sif.t), 32'(it.t));
          chk("issue_busy", 32'(busy), 1);
          pend_mm  = mm[it.ep][it.idx];
          rv_pend  = 1'b1;
          rv_delay = rr ? $urandom_range(0, 2) : 0;
          issues++;
          do_abort = (it.ep == abort_ep);
        end
      end
      tick;
    end
    start            = 1'b0;
    wr_en            = 1'b0;
    sif.result_valid = 1'b0;
    sif.mismatch     = 1'b0;
    if (do_abort) begin
      Rst = 1'b1;
      tick;
      check_zero("abort");
      Rst = 1'b0;
    end else begin
      chk("finish_reached", 32'(Finish_Flag), 1);
      chk("leftover_issues", 32'(exp_q.size()), 0);
      chk("done_epoch", 32'(epoch), 32'(exp_epoch));
      chk("done_conv", 32'(converged), 32'(exp_conv));
      chk("done_lasterr", 32'(last_epoch_err), 32'(exp_last));
      chk("done_busy", 32'(busy), 0);
      chk("done_valid", 32'(sif.sample_valid), 0);
    end
  endtask

  initial begin
    int iss, n;

    vt[0] = '{4,   0, 1'b0, 0, 1'b0,   4,  0, 1'b1, 0};
    vt[1] = '{4,   1, 1'b0, 0, 1'b0,   8,  1, 1'b1, 0};
    vt[2] = '{4,   2, 1'b0, 0, 1'b0,  64, 15, 1'b0, 4};
    vt[3] = '{4,   0, 1'b0, 5, 1'b0,   4,  0, 1'b1, 0};
    vt[4] = '{1,   2, 1'b1, 0, 1'b1,  16, 15, 1'b0, 1};
    vt[5] = '{250, 0, 1'b1, 0, 1'b0, 200,  0, 1'b1, 0};
    vt[6] = '{3,   1, 1'b1, 2, 1'b1,   6,  1, 1'b1, 0};

    Rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_t = '0;
    num_samples = '0; start = 1'b0;
    sif.sample_ready = 1'b0; sif.result_valid = 1'b0; sif.mismatch = 1'b0;
    tick;
    tick;
    check_zero("reset");
    Rst = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(i);
      wr_x1   = 7'($urandom);
      wr_x2   = 7'($urandom);
      wr_t    = 2'($urandom);
      m_x1[i] = wr_x1;
      m_x2[i] = wr_x2;
      m_t[i]  = wr_t;
      tick;
    end
    wr_en = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_mm(vt[v].mode);
      if (vt[v].wr0) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_x1   = 7'($urandom);
        wr_x2   = 7'($urandom);
        wr_t    = 2'($urandom);
        m_x1[0] = wr_x1;
        m_x2[0] = wr_x2;
        m_t[0]  = wr_t;
      end
      build_model((vt[v].n > int'(DEPTH)) ? int'(DEPTH) : vt[v].n);
      run(vt[v].n, vt[v].rr, vt[v].stall, -1, iss);
      chk("vec_issues", 32'(iss), 32'(vt[v].e_issues));
      chk("vec_epoch", 32'(epoch), 32'(vt[v].e_epoch));
      chk("vec_conv", 32'(converged), 32'(vt[v].e_conv));
      chk("vec_lasterr", 32'(last_epoch_err), 32'(vt[v].e_last));
    end

    // Reset while waiting for a result in epoch 1, then replay from a clean start.
    fill_mm(2);
    build_model(4);
    run(4, 1'b0, 0, 1, iss);
    chk("abort_issues", 32'(iss), 5);
    fill_mm(0);
    build_model(4);
    run(4, 1'b0, 0, -1, iss);
    chk("replay_issues", 32'(iss), 4);

    // Empty training set finishes immediately without convergence.
    num_samples = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("empty_finish", 32'(Finish_Flag), 1);
    chk("empty_conv", 32'(converged), 0);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_valid", 32'(sif.sample_valid), 0);
    chk("empty_epoch", 32'(epoch), 0);

    for (int r = 0; r < 8; r++) begin
      fill_mm(3);
      n = $urandom_range(1, 20);
      build_model(n);
      run(n, 1'b1, $urandom_range(0, 3), -1, iss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
